// File: rtl/step_cond_pkg.sv
// Shared definitions for the step conditioner: the FSM state encoding,
// default parameter values and a small constant helper used to size the timer.
package step_cond_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_HELD   = 2'd1,
        ST_REPEAT = 2'd2
    } state_e;

    localparam int DEF_SYNC_STAGES     = 2;
    localparam int DEF_DEBOUNCE_CYCLES = 16;
    localparam int DEF_REPEAT_DELAY    = 64;
    localparam int DEF_REPEAT_PERIOD   = 16;

    function automatic int max_int(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/step_conditioner_debounce.sv
// debounce: synchronizer chain, mismatch counter and stable-level register
// for one asynchronous, bouncing input.
//   clk      - rising-edge clock
//   rst      - asynchronous active-high reset
//   raw_i    - asynchronous raw input
//   stable_o - debounced level
module debounce
    import step_cond_pkg::*;
#(
    parameter int SYNC_STAGES     = DEF_SYNC_STAGES,
    parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES
) (
    input  logic clk,
    input  logic rst,
    input  logic raw_i,
    output logic stable_o
);

    localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

    logic [SYNC_STAGES-1:0] sync_q;
    logic [CW-1:0]          cnt_q;
    logic [CW-1:0]          cnt_d;
    logic                   stable_q;
    logic                   stable_d;
    logic                   synced;

    assign synced = sync_q[SYNC_STAGES-1];

    // The counter only advances while synced disagrees with stable and is
    // cleared on acceptance, so it tops out at DEBOUNCE_CYCLES-1 and never wraps.
    always_comb begin
        cnt_d    = '0;
        stable_d = stable_q;
        if (synced != stable_q) begin
            if (cnt_q == CNT_LAST) begin
                stable_d = synced;
                cnt_d    = '0;
            end else begin
                cnt_d = cnt_q + CW'(1);
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync_q   <= '0;
            cnt_q    <= '0;
            stable_q <= 1'b0;
        end else begin
            sync_q   <= {sync_q[SYNC_STAGES-2:0], raw_i};
            cnt_q    <= cnt_d;
            stable_q <= stable_d;
        end
    end

    assign stable_o = stable_q;

endmodule

// File: rtl/step_conditioner.sv
// step_conditioner: turns a bouncing step button and direction switch into a
// clean one-cycle count enable plus a debounced direction, with optional
// auto-repeat while the button is held.
//   clk        - rising-edge clock
//   rst        - asynchronous active-high reset
//   btn_raw    - asynchronous bouncing step button
//   dir_raw    - asynchronous bouncing direction switch (1 = up)
//   repeat_en  - synchronous auto-repeat enable
//   step_pulse - registered one-cycle count enable
//   dir_stable - debounced direction
//   btn_stable - debounced button level
//   repeating  - high while in auto-repeat
//
// state     | meaning
// ST_IDLE   | button released, waiting for a debounced press
// ST_HELD   | first step issued, timing the initial repeat delay
// ST_REPEAT | auto-repeating every REPEAT_PERIOD cycles
module step_conditioner
    import step_cond_pkg::*;
#(
    parameter int SYNC_STAGES     = DEF_SYNC_STAGES,
    parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
    parameter int REPEAT_DELAY    = DEF_REPEAT_DELAY,
    parameter int REPEAT_PERIOD   = DEF_REPEAT_PERIOD
) (
    input  logic clk,
    input  logic rst,
    input  logic btn_raw,
    input  logic dir_raw,
    input  logic repeat_en,
    output logic step_pulse,
    output logic dir_stable,
    output logic btn_stable,
    output logic repeating
);

    localparam int TW = $clog2(max_int(REPEAT_DELAY, REPEAT_PERIOD) + 1);
    localparam logic [TW-1:0] DELAY_LAST  = TW'(REPEAT_DELAY - 1);
    localparam logic [TW-1:0] PERIOD_LAST = TW'(REPEAT_PERIOD - 1);

    state_e        state_q;
    state_e        state_d;
    logic [TW-1:0] timer_q;
    logic [TW-1:0] timer_d;
    logic          pulse_q;
    logic          pulse_d;
    logic          btn_db;
    logic          dir_db;

    debounce #(
        .SYNC_STAGES    (SYNC_STAGES),
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_btn_db (
        .clk     (clk),
        .rst     (rst),
        .raw_i   (btn_raw),
        .stable_o(btn_db)
    );

    debounce #(
        .SYNC_STAGES    (SYNC_STAGES),
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_dir_db (
        .clk     (clk),
        .rst     (rst),
        .raw_i   (dir_raw),
        .stable_o(dir_db)
    );

    // Release is tested first in every held state so that a release landing
    // on a timer expiry never produces a late step.
    always_comb begin
        state_d = state_q;
        timer_d = timer_q;
        pulse_d = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (btn_db) begin
                    pulse_d = 1'b1;
                    state_d = ST_HELD;
                    timer_d = '0;
                end
            end
            ST_HELD: begin
                if (!btn_db) begin
                    state_d = ST_IDLE;
                    timer_d = '0;
                end else if (repeat_en) begin
                    if (timer_q == DELAY_LAST) begin
                        pulse_d = 1'b1;
                        state_d = ST_REPEAT;
                        timer_d = '0;
                    end else begin
                        timer_d = timer_q + TW'(1);
                    end
                end
                // repeat_en low: timer holds so a later enable resumes the delay
            end
            ST_REPEAT: begin
                if (!btn_db) begin
                    state_d = ST_IDLE;
                    timer_d = '0;
                end else if (!repeat_en) begin
                    state_d = ST_HELD;
                    timer_d = '0;
                end else if (timer_q == PERIOD_LAST) begin
                    pulse_d = 1'b1;
                    timer_d = '0;
                end else begin
                    timer_d = timer_q + TW'(1);
                end
            end
            default: begin
                state_d = ST_IDLE;
                timer_d = '0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
            timer_q <= '0;
            pulse_q <= 1'b0;
        end else begin
            state_q <= state_d;
            timer_q <= timer_d;
            pulse_q <= pulse_d;
        end
    end

    assign step_pulse = pulse_q;
    assign btn_stable = btn_db;
    assign dir_stable = dir_db;
    assign repeating  = (state_q == ST_REPEAT);

endmodule

// File: tb/tb_step_conditioner.sv
module tb_step_conditioner;

    logic clk = 1'b0;
    logic rst;
    logic btn_raw;
    logic dir_raw;
    logic repeat_en;
    logic step_pulse;
    logic dir_stable;
    logic btn_stable;
    logic repeating;

    int checks = 0;
    int errors = 0;
    int cyc;
    int exp_q[$];
    logic prev_pulse = 1'b0;

    step_conditioner dut (
        .clk       (clk),
        .rst       (rst),
        .btn_raw   (btn_raw),
        .dir_raw   (dir_raw),
        .repeat_en (repeat_en),
        .step_pulse(step_pulse),
        .dir_stable(dir_stable),
        .btn_stable(btn_stable),
        .repeating (repeating)
    );

    always #5 clk = ~clk;

    // Edge counter: edge n is the n-th rising edge after reset release.
    always @(posedge clk or posedge rst) begin
        if (rst) cyc <= 0;
        else     cyc <= cyc + 1;
    end

    // Monitor: every step_pulse must match the head of the expected-edge queue.
    initial begin
        forever begin
            @(negedge clk);
            if (!rst) begin
                if (exp_q.size() > 0 && cyc > exp_q[0]) begin
                    checks++;
                    errors++;
                    $display("FAIL pulse_missing: no pulse seen, required at edge %0d (now %0d)", exp_q[0], cyc);
                    void'(exp_q.pop_front());
                end
                if (step_pulse) begin
                    checks++;
                    if (prev_pulse) begin
                        errors++;
                        $display("FAIL pulse_back_to_back: pulse at edge %0d and %0d, required single cycle", cyc - 1, cyc);
                    end else if (exp_q.size() == 0) begin
                        errors++;
                        $display("FAIL pulse_unexpected: pulse at edge %0d, required none", cyc);
                    end else if (exp_q[0] != cyc) begin
                        errors++;
                        $display("FAIL pulse_edge: pulse at edge %0d, required edge %0d", cyc, exp_q[0]);
                    end else begin
                        void'(exp_q.pop_front());
                    end
                end
                prev_pulse = step_pulse;
            end else begin
                prev_pulse = 1'b0;
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: actual %0d required %0d", name, act, exp);
        end
    endtask

    task automatic wait_to(input int n);
        while (cyc < n) @(negedge clk);
    endtask

    task automatic do_reset(input logic b, input logic d, input logic r);
        @(negedge clk);
        rst = 1'b1;
        btn_raw = b;
        dir_raw = d;
        repeat_en = r;
        exp_q.delete();
        repeat (3) @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic end_test(input string name);
        repeat (2) @(negedge clk);
        chk({name, "_pending"}, exp_q.size(), 0);
        exp_q.delete();
    endtask

    initial begin
        rst = 1'b1;
        btn_raw = 1'b0;
        dir_raw = 1'b0;
        repeat_en = 1'b0;

        // Reset state, with raw inputs active while in reset
        repeat (2) @(negedge clk);
        btn_raw = 1'b1;
        dir_raw = 1'b1;
        repeat (3) @(negedge clk);
        chk("rst_step_pulse", int'(step_pulse), 0);
        chk("rst_btn_stable", int'(btn_stable), 0);
        chk("rst_dir_stable", int'(dir_stable), 0);
        chk("rst_repeating",  int'(repeating),  0);

        // Single press, repeat disabled: one pulse at edge 19, stable levels at 18
        do_reset(1'b1, 1'b1, 1'b0);
        exp_q.push_back(19);
        wait_to(17);
        chk("single_btn_stable_17", int'(btn_stable), 0);
        chk("single_dir_stable_17", int'(dir_stable), 0);
        wait_to(18);
        chk("single_btn_stable_18", int'(btn_stable), 1);
        chk("single_dir_stable_18", int'(dir_stable), 1);
        wait_to(120);
        chk("single_repeating", int'(repeating), 0);
        end_test("single");

        // Repeat paused 20 edges mid-delay: first repeat moves from 83 to 103
        do_reset(1'b1, 1'b0, 1'b1);
        exp_q = '{19, 103, 119, 135, 151};
        wait_to(49);
        repeat_en = 1'b0;
        wait_to(69);
        repeat_en = 1'b1;
        wait_to(100);
        chk("pause_repeating_100", int'(repeating), 0);
        wait_to(104);
        chk("pause_repeating_104", int'(repeating), 1);
        wait_to(140);
        btn_raw = 1'b0;
        wait_to(170);
        chk("pause_repeating_170", int'(repeating), 0);
        end_test("pause");

        // Long hold with repeat: 19, 83, 99, ... every 16; dir toggles must not disturb timing
        do_reset(1'b1, 1'b0, 1'b1);
        exp_q.push_back(19);
        for (int k = 0; k <= 14; k++) exp_q.push_back(83 + 16 * k);
        wait_to(82);
        chk("hold_repeating_82", int'(repeating), 0);
        wait_to(84);
        chk("hold_repeating_84", int'(repeating), 1);
        wait_to(150);
        dir_raw = 1'b1;
        wait_to(200);
        chk("hold_dir_stable", int'(dir_stable), 1);
        dir_raw = 1'b0;
        wait_to(300);
        btn_raw = 1'b0;
        wait_to(318);
        chk("hold_repeating_318", int'(repeating), 1);
        wait_to(320);
        chk("hold_repeating_320", int'(repeating), 0);
        chk("hold_btn_stable_320", int'(btn_stable), 0);
        end_test("hold");

        // Release landing on timer expiry: btn_stable falls on edge 114, timer hits 15 there
        do_reset(1'b1, 1'b0, 1'b1);
        exp_q = '{19, 83, 99};
        wait_to(96);
        btn_raw = 1'b0;
        wait_to(113);
        chk("race_btn_stable_113", int'(btn_stable), 1);
        wait_to(114);
        chk("race_btn_stable_114", int'(btn_stable), 0);
        chk("race_repeating_114", int'(repeating), 1);
        wait_to(115);
        chk("race_repeating_115", int'(repeating), 0);
        wait_to(140);
        end_test("race");

        // Bounce every 5 cycles for 200 cycles: never accepted
        do_reset(1'b0, 1'b0, 1'b1);
        begin
            int bad;
            bad = 0;
            for (int i = 0; i < 200; i++) begin
                btn_raw = ((i / 5) % 2) != 0;
                @(negedge clk);
                if (btn_stable) bad++;
            end
            chk("bounce_btn_stable_high_cycles", bad, 0);
        end
        btn_raw = 1'b0;
        end_test("bounce");

        // Async reset mid-REPEAT, then release with button still held
        do_reset(1'b1, 1'b1, 1'b1);
        exp_q = '{19, 83};
        wait_to(90);
        chk("midrep_repeating", int'(repeating), 1);
        chk("midrep_btn_stable", int'(btn_stable), 1);
        chk("midrep_dir_stable", int'(dir_stable), 1);
        end_test("midrep");
        #2;
        rst = 1'b1;
        #1;
        chk("async_rst_step_pulse", int'(step_pulse), 0);
        chk("async_rst_btn_stable", int'(btn_stable), 0);
        chk("async_rst_dir_stable", int'(dir_stable), 0);
        chk("async_rst_repeating",  int'(repeating),  0);
        @(negedge clk);
        exp_q.push_back(19);
        rst = 1'b0;
        wait_to(18);
        chk("rst_held_btn_stable", int'(btn_stable), 1);
        wait_to(40);
        end_test("rst_held");

        // Reset mid-hold with the button released during reset: no pulse afterwards
        #2;
        rst = 1'b1;
        btn_raw = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        wait_to(60);
        chk("rst_released_btn_stable", int'(btn_stable), 0);
        end_test("rst_released");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
